div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multicycle signed 32-bit divider that sits directly downstream of the control unit and consumes its DivCtrl output. It takes rs and rt from the A/B register outputs, runs a 32-iteration restoring division, and returns quotient (LO) and remainder (HI) for the HI/LO muxes (HISrc/LOSrc). It reports completion on DivStop and a zero divisor on DivZero, which the control unit uses for its exception path.

Parameters:
WIDTH, 32, operand/result width; the counter width is clog2(WIDTH)+1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (low = reset asserted).
DivCtrl  input  1  start request from the control unit; sampled only in IDLE.
A  input  WIDTH  dividend (rs), signed two's complement.
B  input  WIDTH  divisor (rt), signed two's complement.
HI  output  WIDTH  remainder; holds its value until the next successful divide.
LO  output  WIDTH  quotient; holds its value until the next successful divide.
DivStop  output  1  one-cycle pulse: HI/LO are valid and updated.
DivZero  output  1  one-cycle pulse: divisor was zero; no result is produced.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; HI=0, LO=0, DivStop=0, DivZero=0; internal remainder, quotient, divisor and counter all 0.
- Reset mid-operation aborts the division; HI/LO are cleared, and no DivStop or DivZero is produced.
- States and transitions:
  - IDLE, DivCtrl=1 at edge k, B==0: DivZero=1 for the cycle after edge k; stay IDLE; HI/LO unchanged.
  - IDLE, DivCtrl=1 at edge k, B!=0: latch |A|, |B|, sign_q=A[31]^B[31], sign_r=A[31]; clear the partial remainder; counter=WIDTH; go to CALC.
  - CALC: one restoring step per edge:
    - shift {rem,quo} left 1;
    - trial = rem - |B| at WIDTH+1 bits;
    - if trial is non-negative, rem=trial and quo[0]=1, else quo[0]=0;
    - counter decrements.
    - At counter==1 go to SIGN. CALC occupies edges k+1..k+32.
  - SIGN (edge k+33):
    - LO = sign_q ? -quo : quo.
    - HI = sign_r ? -rem : rem.
    - DivStop=1 for the following cycle; go to DONE.
  - DONE: DivStop returns to 0 at the next edge; go to IDLE. A new DivCtrl is accepted from the edge after DONE.
- Latency: DivStop is high in the cycle after edge k+33, i.e. 33 cycles after start is sampled. Throughput is one divide per 35 cycles.
- DivCtrl while in CALC, SIGN or DONE is ignored; there is no queuing and no restart.
- Operands A/B are only sampled at the start edge; later changes have no effect.
- Absolute value of 0x80000000 is computed at WIDTH+1 bits so it stays positive 2^31.
- Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000 (wraps), HI=0. No exception is raised.
- Semantics: quotient truncates toward zero; remainder takes the dividend's sign; a zero remainder is never negated to non-zero.
- DivStop and DivZero are never high in the same cycle.
- Every output is a register; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (cpu_pkg) holds:
  - WIDTH default;
  - div state encoding (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3);
  - the shared mult/div handshake pulse convention, so mult_unit reuses it.
- One natural sub-module, div_step: a combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem, next quo. It is instantiated once and reused every CALC cycle.
- The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- A=100, B=7, DivCtrl pulse at edge 0 -> DivStop high only in the cycle after edge 33; LO=14, HI=2.
- A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then A=7, B=-2 -> LO=-3, HI=1.
- A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DivStop pulse, DivZero stays 0. Then A=0x80000000, B=1 -> LO=0x80000000, HI=0.
- A=5, B=0 after a prior 100/7 -> DivZero high exactly one cycle after the start edge; DivStop never asserts; HI=2 and LO=14 unchanged.
- Start 100/7, pulse DivCtrl with A=9, B=3 at edge 10 -> second request ignored; result LO=14, HI=2 at cycle 33; a new start is accepted right after DONE.
- Start 100/7, drive reset low mid-cycle at cycle 10 for 2 cycles -> HI=LO=0 immediately (asynchronous), no DivStop. After reset release, 9/3 gives LO=3, HI=0 at +33 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle mult/div units: default width, divider
// state encoding and the completion-pulse bundle both units drive.
package cpu_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_SIGN = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Each field is a registered single-cycle pulse; at most one is set per cycle.
   typedef struct packed {
      logic stop;
      logic zero;
   } md_status_t;

   localparam md_status_t MD_STATUS_IDLE = '{stop: 1'b0, zero: 1'b0};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {rem,quo} left and
// subtract the divisor when the shifted remainder is large enough.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH:0]   divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH+1:0] rem_full;
   logic             neg;
   logic             unused_rem_msb;

   // Extra guard bit: shifted can reach 2^32-1 when the divisor is 2^31.
   always_comb begin
      shifted  = {rem_i, quo_i[WIDTH-1]};
      trial    = {1'b0, shifted} - {1'b0, divisor_i};
      neg      = trial[WIDTH+1];
      rem_full = neg ? {1'b0, shifted} : trial;
      rem_o    = rem_full[WIDTH-1:0];
      quo_o    = {quo_i[WIDTH-2:0], ~neg};
   end

   assign unused_rem_msb = ^rem_full[WIDTH+1:WIDTH];

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: 32 restoring steps on magnitudes, then sign
// fix-up into HI (remainder) and LO (quotient) with DivStop/DivZero pulses.
module div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DivCtrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivStop,
   output logic             DivZero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_quo_q, sgn_quo_d;
   logic             sgn_rem_q, sgn_rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   md_status_t       status_q, status_d;

   logic signed [WIDTH:0] abs_a;
   logic signed [WIDTH:0] abs_b;
   logic [WIDTH-1:0]      step_rem;
   logic [WIDTH-1:0]      step_quo;
   logic                  unused_abs_a_msb;

   // One bit wider so that |0x80000000| stays +2^31.
   function automatic logic signed [WIDTH:0] abs_ext(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH:0] e;
      e = {v[WIDTH-1], v};
      return e[WIDTH] ? -e : e;
   endfunction

   assign abs_a            = abs_ext(A);
   assign abs_b            = abs_ext(B);
   assign unused_abs_a_msb = abs_a[WIDTH];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      status_d  = MD_STATUS_IDLE;

      unique case (state_q)
         DIV_IDLE: begin
            if (DivCtrl) begin
               if (B == '0) begin
                  status_d.zero = 1'b1;
               end else begin
                  rem_d     = '0;
                  quo_d     = abs_a[WIDTH-1:0];
                  dvs_d     = abs_b;
                  sgn_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
                  sgn_rem_d = A[WIDTH-1];
                  cnt_d     = CNT_W'(WIDTH);
                  state_d   = DIV_CALC;
               end
            end
         end
         DIV_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = DIV_SIGN;
         end
         DIV_SIGN: begin
            // Negating the 0x80000000 magnitude wraps back to itself.
            lo_d          = sgn_quo_q ? -quo_q : quo_q;
            hi_d          = sgn_rem_q ? -rem_q : rem_q;
            status_d.stop = 1'b1;
            state_d       = DIV_DONE;
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= DIV_IDLE;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         sgn_quo_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         status_q  <= MD_STATUS_IDLE;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         sgn_quo_q <= sgn_quo_d;
         sgn_rem_q <= sgn_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         status_q  <= status_d;
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign DivStop = status_q.stop;
   assign DivZero = status_q.zero;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of signed divides plus hand sequences for
// divide-by-zero, ignored mid-operation requests and asynchronous reset.
module tb_div_unit;

   logic        clk;
   logic        reset;
   logic        DivCtrl;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        DivStop;
   logic        DivZero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs[11];

   div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .DivCtrl (DivCtrl),
      .A       (A),
      .B       (B),
      .HI      (HI),
      .LO      (LO),
      .DivStop (DivStop),
      .DivZero (DivZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge (edge k).
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic ezero);
      int early;
      int both;
      early   = 0;
      both    = 0;
      A       = a;
      B       = b;
      DivCtrl = 1'b1;
      @(negedge clk);
      DivCtrl = 1'b0;
      A       = $urandom;
      B       = $urandom | 32'h1;
      check("divzero_at_start", {31'b0, DivZero}, {31'b0, ezero});
      check("divstop_at_start", {31'b0, DivStop}, 32'h0);
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         if (DivStop && DivZero) both++;
         if (cyc < 33 && DivStop) early++;
         if (cyc == 1) check("divzero_one_cycle", {31'b0, DivZero}, 32'h0);
         if (cyc == 33) check("divstop_at_33", {31'b0, DivStop}, {31'b0, ~ezero});
         if (cyc == 34) check("divstop_drops", {31'b0, DivStop}, 32'h0);
      end
      check("divstop_early", early, 32'h0);
      check("stop_and_zero", both, 32'h0);
      check("lo_quotient", LO, elo);
      check("hi_remainder", HI, ehi);
   endtask

   initial begin
      int early;
      vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
      vecs[2]  = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
      vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
      vecs[4]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0};
      vecs[5]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
      vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0};
      vecs[7]  = '{32'hFFFFFFFA,   32'd3,          32'hFFFFFFFE,   32'd0};
      vecs[8]  = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF};
      vecs[9]  = '{32'h80000000,   32'h80000000,   32'd1,          32'd0};
      vecs[10] = '{32'hFFFFFFFF,   32'h7FFFFFFF,   32'd0,          32'hFFFFFFFF};

      reset   = 1'b0;
      DivCtrl = 1'b0;
      A       = '0;
      B       = '0;
      #2;
      check("reset_hi", HI, 32'h0);
      check("reset_lo", LO, 32'h0);
      check("reset_divstop", {31'b0, DivStop}, 32'h0);
      check("reset_divzero", {31'b0, DivZero}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Back-to-back calls also exercise the 35-cycle restart point.
      for (int i = 0; i < 11; i++)
         run_div(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 1'b0);

      run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_div(32'd5, 32'd0, 32'd14, 32'd2, 1'b1);

      // Second request during CALC must be ignored.
      early   = 0;
      A       = 32'd100;
      B       = 32'd7;
      DivCtrl = 1'b1;
      @(negedge clk);
      DivCtrl = 1'b0;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         if (cyc < 33 && DivStop) early++;
         if (cyc == 9) begin
            DivCtrl = 1'b1;
            A       = 32'd9;
            B       = 32'd3;
         end
         if (cyc == 10) DivCtrl = 1'b0;
         if (cyc == 33) begin
            check("ign_divstop_33", {31'b0, DivStop}, 32'h1);
            check("ign_lo", LO, 32'd14);
            check("ign_hi", HI, 32'd2);
         end
         if (cyc == 34) check("ign_divstop_drop", {31'b0, DivStop}, 32'h0);
      end
      check("ign_early_stop", early, 32'h0);
      run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Leave a non-zero LO/HI before the reset abort.
      run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

      early   = 0;
      A       = 32'd100;
      B       = 32'd7;
      DivCtrl = 1'b1;
      @(negedge clk);
      DivCtrl = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("rst_async_lo", LO, 32'h0);
      check("rst_async_hi", HI, 32'h0);
      check("rst_async_stop", {31'b0, DivStop}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (DivStop || DivZero) early++;
      end
      check("rst_no_pulse", early, 32'h0);
      check("rst_lo_held", LO, 32'h0);
      run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
